// File: rtl/booth_control_unit.sv
// Moore sequencer for an 8-bit radix-2 Booth multiplier: load, add/sub, arithmetic shift, 8 iterations.
// Latency: done in cycle 18 (no add/sub) up to 26 (add/sub every iteration) after start is sampled.
// No backpressure: start is only honoured in IDLE and is ignored while busy.
module booth_control_unit (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       q0,
    input  logic       q_m1,
    input  logic [2:0] count,
    output logic       load,
    output logic       add,
    output logic       sub,
    output logic       shift,
    output logic       count_up,
    output logic       cnt_clr,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        TEST  = 3'd2,
        ADD   = 3'd3,
        SUB   = 3'd4,
        SHIFT = 3'd5,
        DONE  = 3'd6
    } state_t;

    state_t state, next_state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        load       = 1'b0;
        add        = 1'b0;
        sub        = 1'b0;
        shift      = 1'b0;
        count_up   = 1'b0;
        cnt_clr    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) next_state = LOAD;
            end
            LOAD: begin
                load       = 1'b1;
                cnt_clr    = 1'b1;
                next_state = TEST;
            end
            TEST: begin
                // Booth recoding of the current multiplier bit pair {Q[0], Q[-1]}
                case ({q0, q_m1})
                    2'b10:   next_state = SUB;
                    2'b01:   next_state = ADD;
                    default: next_state = SHIFT;
                endcase
            end
            ADD: begin
                add        = 1'b1;
                next_state = SHIFT;
            end
            SUB: begin
                sub        = 1'b1;
                next_state = SHIFT;
            end
            SHIFT: begin
                shift = 1'b1;
                // count==7 marks the eighth shift; the counter is never wrapped
                if (count == 3'd7) begin
                    next_state = DONE;
                end else begin
                    count_up   = 1'b1;
                    next_state = TEST;
                end
            end
            DONE: begin
                done       = 1'b1;
                next_state = IDLE;
            end
            default: begin
                busy       = 1'b0;
                next_state = IDLE;
            end
        endcase
    end

endmodule
